ik_mult_scheduler: RTL and testbench
====================================

Name: ik_mult_scheduler

Overview:
- Time-multiplexed inverse-kinematics sequencer for the four wheels:
  - w1 = (1/r)(vx-vy-k1*wz)
  - w2 = (1/r)(vx+vy+k1*wz)
  - w3 = (1/r)(vx+vy-k1*wz)
  - w4 = (1/r)(vx-vy+k1*wz)
- Drives one shared external sequential fixed-point multiplier (start/complete handshake) instead of eight dedicated multipliers.
- Performs the sign-magnitude additions internally.
- Sits between the trajectory/target-velocity source and the per-wheel speed controllers.

Parameters:
- N_WIDTH, 17, word width; sign-magnitude, bit N-1 = sign.
- Q_WIDTH, 8, fractional bits.
- K1_CONST, 17'h01080, k1 = 16.5.
- INV_R_CONST, 17'h00047, 1/r ≈ 0.27734.
- MULT_TIMEOUT, 64, cycles allowed per multiply (only used with the optional feature).

Ports:
- IK_MULT_SCHEDULER_CLOCK_50  in  1  clock.
- IK_MULT_SCHEDULER_RESET_InHigh  in  1  async active-high reset.
- IK_MULT_SCHEDULER_start_InHigh  in  1  request; sampled only in IDLE.
- IK_MULT_SCHEDULER_TARGETVX_InBus  in  N_WIDTH  vx.
- IK_MULT_SCHEDULER_TARGETVY_InBus  in  N_WIDTH  vy.
- IK_MULT_SCHEDULER_TARGETWZ_InBus  in  N_WIDTH  wz.
- IK_MULT_SCHEDULER_multA_OutBus  out  N_WIDTH  multiplicand to shared multiplier.
- IK_MULT_SCHEDULER_multB_OutBus  out  N_WIDTH  multiplier constant.
- IK_MULT_SCHEDULER_multStart_OutHigh  out  1  one-cycle start pulse.
- IK_MULT_SCHEDULER_multResult_InBus  in  N_WIDTH  product.
- IK_MULT_SCHEDULER_multComplete_InHigh  in  1  product valid.
- IK_MULT_SCHEDULER_multOverflow_InHigh  in  1  product overflow, qualified by complete.
- IK_MULT_SCHEDULER_W1_OutBus .. W4_OutBus  out  N_WIDTH each  wheel speeds.
- IK_MULT_SCHEDULER_busy_OutHigh  out  1  sequence in progress.
- IK_MULT_SCHEDULER_done_OutHigh  out  1  one-cycle done pulse.
- IK_MULT_SCHEDULER_ovf_OutHigh  out  1  overflow in the last sequence.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset (async, immediate): state = IDLE; all outputs 0, including W1..W4, multStart, busy, done and ovf.
- States and transitions:
  - IDLE → K_ISSUE on start. vx/vy/wz are latched at that edge; later input changes have no effect.
  - K_ISSUE: multStart=1, multA=wz, multB=K1_CONST → K_WAIT.
  - K_WAIT: capture product P on multComplete → SUM.
  - SUM (1 cycle): compute the four sums s_i using P → W_ISSUE, idx=0.
  - W_ISSUE: multStart=1, multA=s_idx, multB=INV_R_CONST → W_WAIT.
  - W_WAIT: capture result into shadow reg idx on complete. If idx<3: idx++ and → W_ISSUE; else → DONE.
  - DONE: done=1 for exactly one cycle → IDLE.
- Output update: W1..W4 load all four shadow regs together on the edge entering DONE. Outputs hold between sequences.
- Operand hold: multA/multB stay stable from ISSUE until complete is seen. multStart is never asserted in WAIT.
- busy = 1 in every state except IDLE.
- Start handling: start outside IDLE is ignored; no queuing. A multComplete received in IDLE, SUM or DONE is ignored.
- Latency: with multiplier latency L (complete L cycles after the start pulse, L≥1), done is high in cycle 5L+7 after the edge that sampled start.
- Sign-magnitude add/sub (negation = invert sign bit):
  - Equal signs: add magnitudes. A carry out of bit N-2 saturates the magnitude to all ones and sets overflow.
  - Unequal signs: larger magnitude minus smaller; result takes the sign of the larger.
  - A zero result is always +0. A -0 input is treated as +0.
- ovf flag: cleared when start is accepted. Set by any saturated add or any qualified multOverflow during the sequence. Updated with W outputs on entry to DONE.
- Reset mid-sequence aborts immediately. The multiplier is not notified; its late complete is ignored in IDLE.

Optional Feature:
- Macro: IK_MULT_SCHEDULER_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in K_WAIT/W_WAIT and is cleared on each ISSUE.
  - On reaching MULT_TIMEOUT without complete: → IDLE, W outputs unchanged, done stays low, ovf unchanged.
  - Adds port IK_MULT_SCHEDULER_timeout_OutHigh, pulsed for 1 cycle.
- Undefined: no counter and no port; the WAIT states wait indefinitely.

Test Plan:
- Multiplier model L=1 (truncating, product>>8). vx=0x00A00, vy=0, wz=0, start → W1..W4=0x002C6; done in cycle 12; ovf=0; busy high in cycles 1..12.
- vx=0, vy=0, wz=0x00100 → P=0x01080; W1=0x10493, W2=0x00493, W3=0x10493, W4=0x00493.
- vx=0x0FF00, vy=0x1FF00, wz=0 → vx-vy saturates. W1=W4=0x046FF, W2=W3=0x00000 (+0), ovf=1. The next clean sequence clears ovf.
- L=7, with start pulsed again during busy and inputs changed mid-sequence → single done in cycle 42; results reflect latched inputs; multA/multB stable through every wait.
- Reset asserted during the third W_WAIT → busy, multStart and W1..W4 are 0 before the next edge. A subsequent late multComplete causes no state change.
- With TIMEOUT_EN and MULT_TIMEOUT=64, multiplier never completes → timeout pulse 64 cycles after the K_ISSUE cycle; returns to IDLE; previous W values retained; done never asserts.

Source files
------------

// File: rtl/ik_mult_scheduler.sv
// Four-wheel inverse-kinematics sequencer that time-shares one external sign-magnitude multiplier.
// Optional multiply watchdog with timeout pulse port: define IK_MULT_SCHEDULER_TIMEOUT_EN.
module ik_mult_scheduler #(
   parameter int                 N_WIDTH      = 17,
   parameter int                 Q_WIDTH      = 8,
   parameter logic [N_WIDTH-1:0] K1_CONST     = 17'h01080,
   parameter logic [N_WIDTH-1:0] INV_R_CONST  = 17'h00047,
   parameter int                 MULT_TIMEOUT = 64
) (
   input  logic               IK_MULT_SCHEDULER_CLOCK_50,
   input  logic               IK_MULT_SCHEDULER_RESET_InHigh,
   input  logic               IK_MULT_SCHEDULER_start_InHigh,
   input  logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_TARGETVX_InBus,
   input  logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_TARGETVY_InBus,
   input  logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_TARGETWZ_InBus,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_multA_OutBus,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_multB_OutBus,
   output logic               IK_MULT_SCHEDULER_multStart_OutHigh,
   input  logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_multResult_InBus,
   input  logic               IK_MULT_SCHEDULER_multComplete_InHigh,
   input  logic               IK_MULT_SCHEDULER_multOverflow_InHigh,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_W1_OutBus,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_W2_OutBus,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_W3_OutBus,
   output logic [N_WIDTH-1:0] IK_MULT_SCHEDULER_W4_OutBus,
   output logic               IK_MULT_SCHEDULER_busy_OutHigh,
   output logic               IK_MULT_SCHEDULER_done_OutHigh,
`ifdef IK_MULT_SCHEDULER_TIMEOUT_EN
   output logic               IK_MULT_SCHEDULER_timeout_OutHigh,
`endif
   output logic               IK_MULT_SCHEDULER_ovf_OutHigh
);

   localparam int M = N_WIDTH - 1;

   if (Q_WIDTH >= N_WIDTH - 1 || MULT_TIMEOUT < 2) begin : g_bad_cfg
      $error("ik_mult_scheduler: Q_WIDTH must leave integer bits and MULT_TIMEOUT must be >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_K_ISSUE, S_K_WAIT, S_SUM, S_W_ISSUE, S_W_WAIT, S_DONE
   } state_t;

   logic clk, rst, cmp;
   assign clk = IK_MULT_SCHEDULER_CLOCK_50;
   assign rst = IK_MULT_SCHEDULER_RESET_InHigh;
   assign cmp = IK_MULT_SCHEDULER_multComplete_InHigh;

   state_t state_q, state_d;
   logic [1:0]                 idx_q, idx_d;
   logic [N_WIDTH-1:0]         vx_q, vx_d, vy_q, vy_d, wz_q, wz_d, p_q, p_d;
   logic [3:0][N_WIDTH-1:0]    s_q, s_d, sh_q, sh_d, w_q, w_d;
   logic                       acc_ovf_q, acc_ovf_d, ovf_q, ovf_d;
   logic                       wd_expired;

   // Returns {overflow, sign, magnitude}; -0 inputs read as +0 and zero results are always +0.
   function automatic logic [N_WIDTH:0] sm_add(input logic [N_WIDTH-1:0] a,
                                               input logic [N_WIDTH-1:0] b);
      logic [M-1:0] ma, mb, mr;
      logic [M:0]   sum;
      logic         sa, sb, sr, ov;
      ma  = a[M-1:0];
      mb  = b[M-1:0];
      sa  = a[M] & (|ma);
      sb  = b[M] & (|mb);
      ov  = 1'b0;
      sum = '0;
      if (sa == sb) begin
         sum = {1'b0, ma} + {1'b0, mb};
         ov  = sum[M];
         mr  = ov ? '1 : sum[M-1:0];
         sr  = sa;
      end else if (ma >= mb) begin
         mr = ma - mb;
         sr = sa;
      end else begin
         mr = mb - ma;
         sr = sb;
      end
      if (mr == '0) sr = 1'b0;
      return {ov, sr, mr};
   endfunction

   function automatic logic [N_WIDTH-1:0] sm_neg(input logic [N_WIDTH-1:0] x);
      return {~x[M], x[M-1:0]};
   endfunction

   // Shared partial sums: vx-vy feeds w1/w4, vx+vy feeds w2/w3.
   logic [N_WIDTH:0] add_d, add_p, add_s1, add_s2, add_s3, add_s4;
   logic             sum_ovf;
   assign add_d   = sm_add(vx_q, sm_neg(vy_q));
   assign add_p   = sm_add(vx_q, vy_q);
   assign add_s1  = sm_add(add_d[M:0], sm_neg(p_q));
   assign add_s2  = sm_add(add_p[M:0], p_q);
   assign add_s3  = sm_add(add_p[M:0], sm_neg(p_q));
   assign add_s4  = sm_add(add_d[M:0], p_q);
   assign sum_ovf = add_d[N_WIDTH] | add_p[N_WIDTH] | add_s1[N_WIDTH] |
                    add_s2[N_WIDTH] | add_s3[N_WIDTH] | add_s4[N_WIDTH];

`ifdef IK_MULT_SCHEDULER_TIMEOUT_EN
   localparam int WD_W = $clog2(MULT_TIMEOUT + 1);
   logic [WD_W-1:0] wd_q, wd_d;

   always_comb begin
      wd_d = wd_q;
      if (state_q == S_K_ISSUE || state_q == S_W_ISSUE) wd_d = '0;
      else if (state_q == S_K_WAIT || state_q == S_W_WAIT) wd_d = wd_q + WD_W'(1);
   end

   assign wd_expired = (state_q == S_K_WAIT || state_q == S_W_WAIT) && !cmp &&
                       (wd_q == WD_W'(MULT_TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) wd_q <= '0;
      else     wd_q <= wd_d;
   end
`else
   assign wd_expired = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q     <= '0;
         vx_q      <= '0;
         vy_q      <= '0;
         wz_q      <= '0;
         p_q       <= '0;
         s_q       <= '0;
         sh_q      <= '0;
         w_q       <= '0;
         acc_ovf_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         idx_q     <= idx_d;
         vx_q      <= vx_d;
         vy_q      <= vy_d;
         wz_q      <= wz_d;
         p_q       <= p_d;
         s_q       <= s_d;
         sh_q      <= sh_d;
         w_q       <= w_d;
         acc_ovf_q <= acc_ovf_d;
         ovf_q     <= ovf_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      vx_d      = vx_q;
      vy_d      = vy_q;
      wz_d      = wz_q;
      p_d       = p_q;
      s_d       = s_q;
      sh_d      = sh_q;
      w_d       = w_q;
      acc_ovf_d = acc_ovf_q;
      ovf_d     = ovf_q;
      case (state_q)
         S_IDLE: begin
            if (IK_MULT_SCHEDULER_start_InHigh) begin
               vx_d      = IK_MULT_SCHEDULER_TARGETVX_InBus;
               vy_d      = IK_MULT_SCHEDULER_TARGETVY_InBus;
               wz_d      = IK_MULT_SCHEDULER_TARGETWZ_InBus;
               acc_ovf_d = 1'b0;
               state_d   = S_K_ISSUE;
            end
         end
         S_K_ISSUE: state_d = S_K_WAIT;
         S_K_WAIT: begin
            if (cmp) begin
               p_d       = IK_MULT_SCHEDULER_multResult_InBus;
               acc_ovf_d = acc_ovf_q | IK_MULT_SCHEDULER_multOverflow_InHigh;
               state_d   = S_SUM;
            end else if (wd_expired) begin
               state_d = S_IDLE;
            end
         end
         S_SUM: begin
            s_d[0]    = add_s1[M:0];
            s_d[1]    = add_s2[M:0];
            s_d[2]    = add_s3[M:0];
            s_d[3]    = add_s4[M:0];
            acc_ovf_d = acc_ovf_q | sum_ovf;
            idx_d     = 2'd0;
            state_d   = S_W_ISSUE;
         end
         S_W_ISSUE: state_d = S_W_WAIT;
         S_W_WAIT: begin
            if (cmp) begin
               sh_d[idx_q] = IK_MULT_SCHEDULER_multResult_InBus;
               acc_ovf_d   = acc_ovf_q | IK_MULT_SCHEDULER_multOverflow_InHigh;
               if (idx_q == 2'd3) begin
                  // All four wheels publish together so consumers never see a mixed set.
                  w_d     = sh_d;
                  ovf_d   = acc_ovf_d;
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx_q + 2'd1;
                  state_d = S_W_ISSUE;
               end
            end else if (wd_expired) begin
               state_d = S_IDLE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      IK_MULT_SCHEDULER_multA_OutBus      = '0;
      IK_MULT_SCHEDULER_multB_OutBus      = '0;
      IK_MULT_SCHEDULER_multStart_OutHigh = 1'b0;
      IK_MULT_SCHEDULER_busy_OutHigh      = (state_q != S_IDLE);
      IK_MULT_SCHEDULER_done_OutHigh      = (state_q == S_DONE);
      case (state_q)
         S_K_ISSUE, S_K_WAIT: begin
            IK_MULT_SCHEDULER_multA_OutBus      = wz_q;
            IK_MULT_SCHEDULER_multB_OutBus      = K1_CONST;
            IK_MULT_SCHEDULER_multStart_OutHigh = (state_q == S_K_ISSUE);
         end
         S_W_ISSUE, S_W_WAIT: begin
            IK_MULT_SCHEDULER_multA_OutBus      = s_q[idx_q];
            IK_MULT_SCHEDULER_multB_OutBus      = INV_R_CONST;
            IK_MULT_SCHEDULER_multStart_OutHigh = (state_q == S_W_ISSUE);
         end
         default: ;
      endcase
   end

`ifdef IK_MULT_SCHEDULER_TIMEOUT_EN
   assign IK_MULT_SCHEDULER_timeout_OutHigh = wd_expired;
`endif

   assign IK_MULT_SCHEDULER_W1_OutBus   = w_q[0];
   assign IK_MULT_SCHEDULER_W2_OutBus   = w_q[1];
   assign IK_MULT_SCHEDULER_W3_OutBus   = w_q[2];
   assign IK_MULT_SCHEDULER_W4_OutBus   = w_q[3];
   assign IK_MULT_SCHEDULER_ovf_OutHigh = ovf_q;

endmodule

// File: tb/tb_ik_mult_scheduler.sv
// Bench for ik_mult_scheduler: variable-latency multiplier model plus integer-arithmetic reference.
module tb_ik_mult_scheduler;

   localparam logic [16:0] K1   = 17'h01080;
   localparam logic [16:0] INVR = 17'h00047;

   logic        clk = 1'b0;
   logic        rst, start, mcmp, movf;
   logic [16:0] tvx, tvy, twz, mres, ma, mb, w1, w2, w3, w4;
   logic        mstart, busy, done, ovf;
   logic [16:0] wv [4];

   always #5 clk = ~clk;

   assign wv[0] = w1;
   assign wv[1] = w2;
   assign wv[2] = w3;
   assign wv[3] = w4;

   ik_mult_scheduler dut (
      .IK_MULT_SCHEDULER_CLOCK_50           (clk),
      .IK_MULT_SCHEDULER_RESET_InHigh       (rst),
      .IK_MULT_SCHEDULER_start_InHigh       (start),
      .IK_MULT_SCHEDULER_TARGETVX_InBus     (tvx),
      .IK_MULT_SCHEDULER_TARGETVY_InBus     (tvy),
      .IK_MULT_SCHEDULER_TARGETWZ_InBus     (twz),
      .IK_MULT_SCHEDULER_multA_OutBus       (ma),
      .IK_MULT_SCHEDULER_multB_OutBus       (mb),
      .IK_MULT_SCHEDULER_multStart_OutHigh  (mstart),
      .IK_MULT_SCHEDULER_multResult_InBus   (mres),
      .IK_MULT_SCHEDULER_multComplete_InHigh(mcmp),
      .IK_MULT_SCHEDULER_multOverflow_InHigh(movf),
      .IK_MULT_SCHEDULER_W1_OutBus          (w1),
      .IK_MULT_SCHEDULER_W2_OutBus          (w2),
      .IK_MULT_SCHEDULER_W3_OutBus          (w3),
      .IK_MULT_SCHEDULER_W4_OutBus          (w4),
      .IK_MULT_SCHEDULER_busy_OutHigh       (busy),
      .IK_MULT_SCHEDULER_done_OutHigh       (done),
      .IK_MULT_SCHEDULER_ovf_OutHigh        (ovf)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // ---- reference arithmetic on plain integers ----
   bit          m_ovf;
   logic [16:0] exp_w [4];
   bit          exp_o;

   function automatic int sm2i(input logic [16:0] v);
      return v[16] ? -int'(v[15:0]) : int'(v[15:0]);
   endfunction

   function automatic logic [16:0] i2sm(input int x);
      int m;
      m = (x < 0) ? -x : x;
      return {(x < 0) ? 1'b1 : 1'b0, m[15:0]};
   endfunction

   function automatic int sat(input int x);
      if (x > 65535)  begin m_ovf = 1'b1; return 65535;  end
      if (x < -65535) begin m_ovf = 1'b1; return -65535; end
      return x;
   endfunction

   // Truncating Q8 multiply; returns {overflow, sign-magnitude product}.
   function automatic logic [17:0] mul_sm(input logic [16:0] a, input logic [16:0] b);
      longint p;
      bit     o, ng;
      p  = (longint'(a[15:0]) * longint'(b[15:0])) >>> 8;
      o  = (p > 65535);
      if (o) p = 65535;
      ng = (a[16] ^ b[16]) && (p != 0);
      return {o, ng, p[15:0]};
   endfunction

   task automatic ref_model(input logic [16:0] vx, input logic [16:0] vy, input logic [16:0] wz);
      logic [17:0] pm;
      int p, a, b;
      int s [4];
      m_ovf = 1'b0;
      pm    = mul_sm(wz, K1);
      if (pm[17]) m_ovf = 1'b1;
      p    = sm2i(pm[16:0]);
      a    = sat(sm2i(vx) - sm2i(vy));
      b    = sat(sm2i(vx) + sm2i(vy));
      s[0] = sat(a - p);
      s[1] = sat(b + p);
      s[2] = sat(b - p);
      s[3] = sat(a + p);
      for (int i = 0; i < 4; i++) begin
         pm = mul_sm(i2sm(s[i]), INVR);
         if (pm[17]) m_ovf = 1'b1;
         exp_w[i] = pm[16:0];
      end
      exp_o = m_ovf;
   endtask

   // ---- shared multiplier model: complete arrives mult_lat cycles after the start pulse ----
   int          mult_lat = 1;
   int          starts   = 0;
   bit          pending  = 1'b0;
   int          cnt;
   logic [16:0] cap_a, cap_b;

   initial begin
      mcmp = 1'b0;
      movf = 1'b0;
      mres = '0;
      forever begin
         @(negedge clk);
         mcmp = 1'b0;
         movf = 1'b0;
         if (pending) begin
            if (busy) begin
               chk("opA_hold", ma, cap_a);
               chk("opB_hold", mb, cap_b);
               chk("no_start_in_wait", mstart, 1'b0);
            end
            cnt--;
            if (cnt == 0) begin
               {movf, mres} = mul_sm(cap_a, cap_b);
               mcmp    = 1'b1;
               pending = 1'b0;
            end
         end else if (mstart) begin
            cap_a   = ma;
            cap_b   = mb;
            cnt     = mult_lat;
            pending = 1'b1;
            starts++;
         end
      end
   end

   task automatic run_seq(input logic [16:0] vx, input logic [16:0] vy, input logic [16:0] wz,
                          input int lat, input bit disturb);
      int k;
      ref_model(vx, vy, wz);
      mult_lat = lat;
      @(negedge clk);
      tvx   = vx;
      tvy   = vy;
      twz   = wz;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k     = 1;
      chk("busy_cycle1", busy, 1'b1);
      while (!done && k < 1000) begin
         if (disturb && k == 2) begin
            tvx = ~tvx;
            tvy = 17'h00123;
            twz = 17'h10777;
         end
         start = disturb && (k == 3 || k == 20);
         @(negedge clk);
         k++;
      end
      start = 1'b0;
      chk("done_cycle", k, 5 * lat + 7);
      chk("busy_in_done", busy, 1'b1);
      for (int i = 0; i < 4; i++) chk("wheel", wv[i], exp_w[i]);
      chk("ovf", ovf, exp_o);
      @(negedge clk);
      chk("done_one_cycle", done, 1'b0);
      chk("busy_idle", busy, 1'b0);
      chk("w1_hold", w1, exp_w[0]);
   endtask

   initial begin
      int s0, k;
      rst   = 1'b1;
      start = 1'b0;
      tvx   = '0;
      tvy   = '0;
      twz   = '0;
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ovf", ovf, 1'b0);
      chk("rst_mstart", mstart, 1'b0);
      chk("rst_w1", w1, 17'h0);
      chk("rst_w4", w4, 17'h0);
      @(negedge clk);
      rst = 1'b0;

      run_seq(17'h00A00, 17'h00000, 17'h00000, 1, 1'b0);
      chk("plan1_w3", w3, 17'h002C6);
      run_seq(17'h00000, 17'h00000, 17'h00100, 1, 1'b0);
      chk("plan2_w1", w1, 17'h10493);
      run_seq(17'h0FF00, 17'h1FF00, 17'h00000, 1, 1'b0);
      chk("plan3_w2_pos0", w2, 17'h00000);
      chk("plan3_ovf", ovf, 1'b1);
      run_seq(17'h00300, 17'h10100, 17'h00020, 2, 1'b0);
      chk("plan3_ovf_clear", ovf, 1'b0);
      run_seq(17'h00480, 17'h10200, 17'h10040, 7, 1'b1);

      for (int t = 0; t < 8; t++) begin
         logic [16:0] rx, ry, rz;
         rx = {1'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095))};
         ry = {1'($urandom), ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 4095))};
         rz = {1'($urandom), 16'($urandom_range(0, 4095))};
         run_seq(rx, ry, rz, int'($urandom_range(1, 8)), 1'($urandom));
      end

      // Abort in the third W wait; the multiplier's late complete must land harmlessly in IDLE.
      mult_lat = 7;
      s0 = starts;
      @(negedge clk);
      tvx   = 17'h00500;
      tvy   = 17'h00100;
      twz   = 17'h00010;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (starts < s0 + 4 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("reached_third_w", (starts >= s0 + 4), 1'b1);
      @(negedge clk);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", busy, 1'b0);
      chk("abort_mstart", mstart, 1'b0);
      chk("abort_w1", w1, 17'h0);
      chk("abort_w2", w2, 17'h0);
      chk("abort_w3", w3, 17'h0);
      chk("abort_w4", w4, 17'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (12) @(negedge clk);
      chk("late_cmp_busy", busy, 1'b0);
      chk("late_cmp_done", done, 1'b0);
      chk("late_cmp_w1", w1, 17'h0);

      run_seq(17'h01234, 17'h10456, 17'h00033, 3, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
